// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module : lsu_pkg
// Brief  : Shared funct3 codes, FSM states, lane widths and the fault decoder
//          for the load/store unit.
// Rev    : 1.0
// ============================================================================
package lsu_pkg;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;
    localparam int WORD_W = 32;

    localparam logic [WORD_W-1:0] BYTE_MASK = 32'h0000_00FF;
    localparam logic [WORD_W-1:0] HALF_MASK = 32'h0000_FFFF;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        RMW_READ = 3'd2,
        WRITE    = 3'd3,
        RESP     = 3'd4
    } lsu_state_e;

    // Unsigned variants exist only for loads; everything else undefined is illegal.
    function automatic logic lsu_fault(input logic [2:0] funct3,
                                       input logic       is_store,
                                       input logic [1:0] addr_lo);
        logic f;
        case (funct3)
            F3_B:    f = 1'b0;
            F3_H:    f = addr_lo[0];
            F3_W:    f = |addr_lo;
            F3_BU:   f = is_store;
            F3_HU:   f = is_store | addr_lo[0];
            default: f = 1'b1;
        endcase
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module : lsu_align
// Brief  : Combinational lane extract / sign-extend for loads and
//          byte/halfword merge into a read word for sub-word stores.
// Rev    : 1.0
// ============================================================================
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]        funct3_i,
    input  logic [1:0]        offset_i,
    input  logic [WORD_W-1:0] word_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] load_o,
    output logic [WORD_W-1:0] merge_o
);

    logic [4:0]        shamt;
    logic [WORD_W-1:0] lane;

    assign shamt = {offset_i, 3'b000};
    assign lane  = word_i >> shamt;

    always_comb begin
        load_o = lane;
        case (funct3_i)
            F3_B:    load_o = {{(WORD_W-BYTE_W){lane[BYTE_W-1]}}, lane[BYTE_W-1:0]};
            F3_BU:   load_o = {{(WORD_W-BYTE_W){1'b0}}, lane[BYTE_W-1:0]};
            F3_H:    load_o = {{(WORD_W-HALF_W){lane[HALF_W-1]}}, lane[HALF_W-1:0]};
            F3_HU:   load_o = {{(WORD_W-HALF_W){1'b0}}, lane[HALF_W-1:0]};
            default: load_o = lane;
        endcase
    end

    always_comb begin
        merge_o = wdata_i;
        case (funct3_i)
            F3_B:    merge_o = (word_i & ~(BYTE_MASK << shamt)) | ((wdata_i & BYTE_MASK) << shamt);
            F3_H:    merge_o = (word_i & ~(HALF_MASK << shamt)) | ((wdata_i & HALF_MASK) << shamt);
            default: merge_o = wdata_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module : load_store_unit
// Brief  : RV32I load/store unit in front of a word-only data memory; sub-word
//          stores are done as read-modify-write.
// Rev    : 1.0
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_fault,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_read_data
);

    lsu_state_e        state_q, state_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] merge_q, merge_d;
    logic [WORD_W-1:0] rdata_q, rdata_d;
    logic              fault_q, fault_d;
    logic [WORD_W-1:0] load_word;
    logic [WORD_W-1:0] merged_word;

    // merge_q holds the raw store data until RMW_READ overwrites it with the merged word.
    lsu_align u_align (
        .funct3_i (funct3_q),
        .offset_i (addr_q[1:0]),
        .word_i   (mem_read_data),
        .wdata_i  (merge_q),
        .load_o   (load_word),
        .merge_o  (merged_word)
    );

    always_comb begin
        state_d    = state_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        merge_d    = merge_q;
        rdata_d    = rdata_q;
        fault_d    = fault_q;
        req_ready  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        resp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    merge_d  = req_wdata;
                    if (lsu_fault(req_funct3, req_is_store, req_addr[1:0])) begin
                        state_d = RESP;
                        rdata_d = '0;
                        fault_d = 1'b1;
                    end else if (!req_is_store) begin
                        state_d = LOAD;
                    end else if (req_funct3 == F3_W) begin
                        state_d = WRITE;
                    end else begin
                        state_d = RMW_READ;
                    end
                end
            end
            LOAD: begin
                mem_read = 1'b1;
                rdata_d  = load_word;
                fault_d  = 1'b0;
                state_d  = RESP;
            end
            RMW_READ: begin
                mem_read = 1'b1;
                merge_d  = merged_word;
                state_d  = WRITE;
            end
            WRITE: begin
                mem_write = 1'b1;
                rdata_d   = '0;
                fault_d   = 1'b0;
                state_d   = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            funct3_q <= '0;
            addr_q   <= '0;
            merge_q  <= '0;
            rdata_q  <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            merge_q  <= merge_d;
            rdata_q  <= rdata_d;
            fault_q  <= fault_d;
        end
    end

    assign mem_address    = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_write_data = merge_q;
    assign resp_rdata     = rdata_q;
    assign resp_fault     = fault_q;

endmodule
`default_nettype wire
